ncpu32k_cell_pipearb: RTL and testbench
=======================================

// Module: ncpu32k_cell_pipearb
// PURPOSE
//  Round-robin arbiter fused with a 1-slot pipe buffer: shares one buffered
//  valid/ready channel between NREQ requesters (e.g. I-fetch/D-access onto
//  one bus port). Picks one valid requester per accept, registers its data
//  and a one-hot owner tag, and presents them downstream.
//  Throughput: one transfer per cycle when downstream is ready.
// PARAMETERS
//  NREQ           2   number of requesters, 2..8
//  DW             32  data width in bits per requester
//  ENABLE_BYPASS  1   1: slot may be refilled in the same cycle it is popped
//                     0: a new accept is allowed only while the slot is empty
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        reset: one clock; reset is asynchronous and active-high
//  req_valid  in   NREQ     per-requester valid
//  req_ready  out  NREQ     per-requester ready, at most one bit set
//  req_data   in   NREQ*DW  requester i data at [i*DW +: DW]
//  out_valid  out  1        slot holds a transfer
//  out_ready  in   1        downstream accepts the slot contents
//  dout       out  DW       buffered data
//  out_grant  out  NREQ     one-hot owner of dout; 0 when slot empty
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, dout=0, out_grant=0, rr_ptr=0
//    (requester 0 highest priority). Outputs are stable while rst is held.
//  - pop  = out_valid & out_ready.
//  - free = ~out_valid | pop  (ENABLE_BYPASS=1);  free = ~out_valid  (=0).
//  - Winner w: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ...
//    modulo NREQ. Combinational; depends on req_valid, not on req_ready.
//  - req_ready[w] = free & |req_valid; all other req_ready bits are 0.
//    A requester may see req_ready=1 only while it drives req_valid=1.
//  - push = free & |req_valid. On push: dout<=req_data[w], out_grant<=1<<w,
//    out_valid<=1, rr_ptr<=(w+1) mod NREQ.
//  - pop without push: out_valid<=0, out_grant<=0, dout holds its value.
//  - push and pop in one cycle (bypass only): slot is replaced, out_valid
//    stays 1, zero bubble.
//  - No push: rr_ptr holds. Idle cycles do not rotate priority.
//  - Latency: req accept -> out_valid is 1 cycle. No combinational path
//    from req_* to out_* and none from out_ready to dout.
//  - out_ready -> req_ready is a combinational path only with ENABLE_BYPASS=1.
//  - Fairness: a requester holding req_valid waits at most NREQ-1 pushes.
//  - Requester protocol: once valid is asserted, hold valid and data stable
//    until req_ready. The arbiter does not check this; the bench does.
//  - Downstream protocol: dout and out_grant are stable while
//    out_valid & ~out_ready.
//  - Full slot with out_ready=0: all req_ready=0 and rr_ptr holds.
//  - Reset mid-transfer: the buffered transfer is dropped, with no partial
//    state. Pending requesters retry after reset is released.
// TESTING
//  1 Reset: rst=1 with random inputs -> out_valid=0, out_grant=0, dout=0,
//    req_ready=0.
//  2 Single requester, NREQ=2, out_ready=1: req_valid=01, data 0x11,0x22,
//    0x33 -> dout=0x11,0x22,0x33 on successive cycles, out_grant=01.
//  3 Contention, NREQ=4: all req_valid=1, out_ready=1 -> out_grant sequence
//    0001,0010,0100,1000,0001.
//  4 Backpressure: out_ready=0 with the slot full -> req_ready=0000 and
//    dout/out_grant stable for 5 cycles. Release gives one pop, then the
//    next winner in rotation.
//  5 Bypass: ENABLE_BYPASS=1, continuous traffic -> 1 transfer per cycle.
//    ENABLE_BYPASS=0 -> a bubble after every pop (50% throughput).
//  6 Async reset asserted between clock edges with out_valid=1 ->
//    out_valid=0 immediately. After release, requester 0 is served first.

Source files
------------

// File: rtl/ncpu32k_cell_pipearb.sv
// Round-robin arbiter fused with a one-slot pipe buffer.
// Several requesters share one registered valid/ready channel.
module ncpu32k_cell_pipearb #(
  parameter int NREQ          = 2,
  parameter int DW            = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      dout,
  output logic [NREQ-1:0]    out_grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] win_lo;
  logic [PW-1:0] win_hi;
  logic [PW-1:0] win_nxt;
  logic          hi_found;
  logic          any_req;
  logic          pop;
  logic          free;
  logic          push;

  assign any_req = |req_valid;
  assign pop     = out_valid & out_ready;

  generate
    if (ENABLE_BYPASS != 0) begin : g_byp
      assign free = ~out_valid | pop;
    end else begin : g_nobyp
      assign free = ~out_valid;
    end
  endgenerate

  // Nothing is accepted while reset is held.
  assign push = free & any_req & ~rst;

  // Lowest valid index at/after rr_ptr, else wrap to lowest valid overall.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_lo = PW'(i);
        if (PW'(i) >= rr_ptr) begin
          win_hi   = PW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? win_hi : win_lo;
  end

  assign win_nxt =
    (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  assign req_ready =
    push ? (NREQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_grant <= '0;
      dout      <= '0;
      rr_ptr    <= '0;
    end else if (push) begin
      out_valid <= 1'b1;
      out_grant <= NREQ'(1) << win;
      dout      <= req_data[int'(win)*DW +: DW];
      rr_ptr    <= win_nxt;
    end else if (pop) begin
      out_valid <= 1'b0;
      out_grant <= '0;
    end
  end

endmodule

// File: tb/tb_ncpu32k_cell_pipearb.sv
// Directed bench for ncpu32k_cell_pipearb: NREQ=2 and NREQ=4,
// with and without bypass.
module tb_ncpu32k_cell_pipearb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0]   v2, r2, g2;
  logic [63:0]  d2;
  logic         ov2, or2;
  logic [31:0]  do2;

  logic [3:0]   v4, r4, g4;
  logic [127:0] d4;
  logic         ov4, or4;
  logic [31:0]  do4;

  logic [3:0]   vn, rn, gn;
  logic [127:0] dn;
  logic         ovn, orn;
  logic [31:0]  don;

  ncpu32k_cell_pipearb #(.NREQ(2), .DW(32), .ENABLE_BYPASS(1)) u2 (
    .clk(clk), .rst(rst),
    .req_valid(v2), .req_ready(r2), .req_data(d2),
    .out_valid(ov2), .out_ready(or2), .dout(do2), .out_grant(g2)
  );

  ncpu32k_cell_pipearb #(.NREQ(4), .DW(32), .ENABLE_BYPASS(1)) u4 (
    .clk(clk), .rst(rst),
    .req_valid(v4), .req_ready(r4), .req_data(d4),
    .out_valid(ov4), .out_ready(or4), .dout(do4), .out_grant(g4)
  );

  ncpu32k_cell_pipearb #(.NREQ(4), .DW(32), .ENABLE_BYPASS(0)) un (
    .clk(clk), .rst(rst),
    .req_valid(vn), .req_ready(rn), .req_data(dn),
    .out_valid(ovn), .out_ready(orn), .dout(don), .out_grant(gn)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0]  exp_g [5];
  logic [31:0] exp_d [5];
  int cnt4, cntn;

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};

    // 1: reset with random inputs
    v2  = 2'($urandom);  d2 = {$urandom, $urandom};
    v4  = 4'($urandom);  d4 = {4{$urandom}};
    vn  = 4'($urandom);  dn = {4{$urandom}};
    or2 = 1'($urandom);  or4 = 1'($urandom); orn = 1'($urandom);
    repeat (3) tick();
    check("rst_ov2", 64'(ov2), 0);
    check("rst_g2",  64'(g2),  0);
    check("rst_d2",  64'(do2), 0);
    check("rst_r2",  64'(r2),  0);
    check("rst_ov4", 64'(ov4), 0);
    check("rst_g4",  64'(g4),  0);
    check("rst_d4",  64'(do4), 0);
    check("rst_r4",  64'(r4),  0);
    check("rst_ovn", 64'(ovn), 0);
    check("rst_rn",  64'(rn),  0);

    v2 = '0; v4 = '0; vn = '0;
    or2 = 1'b1; or4 = 1'b1; orn = 1'b1;
    rst = 1'b0;
    tick();
    check("idle_ov4", 64'(ov4), 0);

    // 2: single requester on NREQ=2
    v2 = 2'b01;
    d2 = {32'hDEAD_BEEF, 32'h11};
    #1;
    check("t2_ready", 64'(r2), 64'h1);
    tick();
    check("t2_d0", 64'(do2), 64'h11);
    check("t2_g0", 64'(g2),  64'h1);
    d2[31:0] = 32'h22;
    tick();
    check("t2_d1", 64'(do2), 64'h22);
    check("t2_g1", 64'(g2),  64'h1);
    d2[31:0] = 32'h33;
    tick();
    check("t2_d2", 64'(do2), 64'h33);
    check("t2_v2", 64'(ov2), 64'h1);
    v2 = 2'b00;
    tick();
    check("t2_drain_ov", 64'(ov2), 0);
    check("t2_drain_g",  64'(g2),  0);
    check("t2_drain_d",  64'(do2), 64'h33);

    // 3: full contention on NREQ=4
    d4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    v4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t3_ready%0d", k), 64'(r4), 64'(exp_g[k]));
      tick();
      check($sformatf("t3_g%0d", k), 64'(g4),  64'(exp_g[k]));
      check($sformatf("t3_d%0d", k), 64'(do4), 64'(exp_d[k]));
    end

    // 4: backpressure with slot full
    or4 = 1'b0;
    #1;
    check("t4_ready_block", 64'(r4), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t4_g%0d", k),  64'(g4),  64'h1);
      check($sformatf("t4_d%0d", k),  64'(do4), 64'hA0);
      check($sformatf("t4_r%0d", k),  64'(r4),  0);
    end
    or4 = 1'b1;
    #1;
    check("t4_release_ready", 64'(r4), 64'b0010);
    tick();
    check("t4_next_g", 64'(g4),  64'b0010);
    check("t4_next_d", 64'(do4), 64'hA1);
    v4 = 4'b0000;
    tick();
    check("t4_pop_ov", 64'(ov4), 0);
    check("t4_pop_d",  64'(do4), 64'hA1);

    // 5: throughput with and without bypass
    v4 = 4'b0001;
    vn = 4'b0001;
    dn = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    cnt4 = 0;
    cntn = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ov4) cnt4++;
      if (ovn) cntn++;
      if (k % 2 == 0)
        check($sformatf("t5_nb_ready%0d", k), 64'(rn), 0);
    end
    check("t5_bypass_xfers", 64'(cnt4), 64'd8);
    check("t5_nobyp_xfers",  64'(cntn), 64'd4);
    check("t5_nobyp_data",   64'(don),  64'hB0);
    v4 = '0;
    vn = '0;
    tick();

    // 6: async reset between edges with a full slot
    v4 = 4'b0100;
    or4 = 1'b0;
    tick();
    check("t6_full_g", 64'(g4),  64'b0100);
    check("t6_full_v", 64'(ov4), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_ov", 64'(ov4), 0);
    check("t6_async_g",  64'(g4),  0);
    check("t6_async_d",  64'(do4), 0);
    v4 = 4'b1111;
    or4 = 1'b1;
    tick();
    check("t6_hold_ov", 64'(ov4), 0);
    check("t6_hold_r",  64'(r4),  0);
    rst = 1'b0;
    #1;
    check("t6_rel_ready", 64'(r4), 64'b0001);
    tick();
    check("t6_first_g", 64'(g4),  64'b0001);
    check("t6_first_d", 64'(do4), 64'hA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
